// File: rtl/rx_baud_pkg.sv
// Shared types and constants for the UART RX baud tracker.
//   state_e      : tracker FSM states
//   MIN_PRESCALE : smallest legal oversampling ratio
//   SMP_*        : sample_idx encodings for early/mid/late samples
package rx_baud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam int unsigned MIN_PRESCALE = 4;

  localparam logic [1:0] SMP_EARLY = 2'd0;
  localparam logic [1:0] SMP_MID   = 2'd1;
  localparam logic [1:0] SMP_LATE  = 2'd2;

endpackage

// File: rtl/rx_baud_tracker_if.sv
// Bundle between the RX control FSM (master) and the baud tracker (slave).
//   cnt_enable/prescale/frame_bits : control and configuration from the FSM
//   edge_cnt/bit_cnt               : position within bit / frame
//   last_edge_flag/frame_done      : bit and frame boundary flags
//   sample_strobe/sample_idx       : sampling points for the data sampler
//   cfg_err                        : latched configuration was illegal
interface rx_baud_tracker_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  cnt_enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  last_edge_flag;
  logic                  sample_strobe;
  logic [1:0]            sample_idx;
  logic                  frame_done;
  logic                  cfg_err;

  modport master (
    output cnt_enable, prescale, frame_bits,
    input  edge_cnt, bit_cnt, last_edge_flag, sample_strobe, sample_idx,
           frame_done, cfg_err
  );

  modport slave (
    input  cnt_enable, prescale, frame_bits,
    output edge_cnt, bit_cnt, last_edge_flag, sample_strobe, sample_idx,
           frame_done, cfg_err
  );
endinterface

// File: rtl/rx_sample_pos_decode.sv
// Combinational decode of sample positions within a bit period.
//   prescale_i  : latched prescale P
//   edge_cnt_i  : edge position to decode (1..P)
//   strobe_c_o  : edge_cnt_i is a sample position
//   idx_c_o     : which sample (early/mid/late)
// Build option RX_BAUD_SAMPLE3_EN: three samples at mid-1/mid/mid+1;
// otherwise a single sample at mid.
module rx_sample_pos_decode
  import rx_baud_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  output logic                  strobe_c_o,
  output logic [1:0]            idx_c_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] mid;

  always_comb begin
    mid        = prescale_i >> 1;
    strobe_c_o = 1'b0;
    idx_c_o    = SMP_EARLY;
`ifdef RX_BAUD_SAMPLE3_EN
    // mid >= 2 for legal prescale, so mid-1 never wraps in use
    if (edge_cnt_i == mid - ONE) begin
      strobe_c_o = 1'b1;
      idx_c_o    = SMP_EARLY;
    end else if (edge_cnt_i == mid) begin
      strobe_c_o = 1'b1;
      idx_c_o    = SMP_MID;
    end else if (edge_cnt_i == mid + ONE) begin
      strobe_c_o = 1'b1;
      idx_c_o    = SMP_LATE;
    end
`else
    if (edge_cnt_i == mid) begin
      strobe_c_o = 1'b1;
      idx_c_o    = SMP_MID;
    end
`endif
  end

endmodule

// File: rtl/rx_baud_tracker.sv
// Oversampling edge/bit counter for the UART receive path.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : rx_baud_tracker_if.slave (enable/config in, counts/strobes out)
// Build option RX_BAUD_SAMPLE3_EN selects 3-sample strobes (see
// rx_sample_pos_decode). All outputs are registered; flags are computed
// from next-state values so they line up with the edge_cnt they decode.
module rx_baud_tracker
  import rx_baud_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  rx_baud_tracker_if.slave   bus
);

  localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BIT_CNT_W-1:0]  f_q, f_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  last_q, last_d;
  logic                  strobe_q, strobe_d;
  logic [1:0]            idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  dec_strobe;
  logic [1:0]            dec_idx;
  logic                  cfg_ok;
  logic                  in_count;

  rx_sample_pos_decode #(.PRESCALE_W(PRESCALE_W)) u_decode (
    .prescale_i (p_q),
    .edge_cnt_i (edge_d),
    .strobe_c_o (dec_strobe),
    .idx_c_o    (dec_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      f_q      <= '0;
      edge_q   <= '0;
      bit_q    <= '0;
      last_q   <= 1'b0;
      strobe_q <= 1'b0;
      idx_q    <= SMP_EARLY;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      f_q      <= f_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counters and flags
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    f_d      = f_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    cfg_ok   = (p_q >= P_MIN) && (f_q != '0);

    unique case (state_q)
      ST_IDLE: begin
        edge_d = E_ONE;
        bit_d  = '0;
        // Config tracks the inputs until enable; the value seen on the
        // last disabled cycle is what gets checked and used.
        if (!bus.cnt_enable) begin
          p_d = bus.prescale;
          f_d = bus.frame_bits;
        end else begin
          state_d = cfg_ok ? ST_COUNT : ST_ERR;
        end
      end
      ST_COUNT: begin
        if (edge_q == p_q) begin
          edge_d = E_ONE;
          if (bit_q == f_q - B_ONE) begin
            state_d = ST_DONE;
            bit_d   = f_q;
          end else begin
            bit_d = bit_q + B_ONE;
          end
        end else begin
          edge_d = edge_q + E_ONE;
        end
      end
      ST_DONE: begin
        edge_d = E_ONE;
        bit_d  = f_q;
      end
      ST_ERR: begin
        edge_d = E_ONE;
        bit_d  = '0;
      end
    endcase

    // Disable wins from any state, including mid-frame
    if (!bus.cnt_enable) begin
      state_d = ST_IDLE;
      edge_d  = E_ONE;
      bit_d   = '0;
    end

    in_count = (state_d == ST_COUNT);
    last_d   = in_count && (edge_d == p_q);
    done_d   = last_d && (bit_d == f_q - B_ONE);
    strobe_d = in_count && dec_strobe;
    idx_d    = strobe_d ? dec_idx : SMP_EARLY;
    err_d    = (state_d == ST_ERR);
  end

  assign bus.edge_cnt       = edge_q;
  assign bus.bit_cnt        = bit_q;
  assign bus.last_edge_flag = last_q;
  assign bus.sample_strobe  = strobe_q;
  assign bus.sample_idx     = idx_q;
  assign bus.frame_done     = done_q;
  assign bus.cfg_err        = err_q;

endmodule
